// File: rtl/led_bus_arbiter_if.sv
// Requester-side and register-bus-side signals of the LED bus arbiter.
// The arbiter uses the slave view; the surrounding logic uses the master view.
interface led_bus_arbiter_if #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned ADDR_BITS = 4,
  parameter int unsigned DATA_BITS = 8
);
  localparam int unsigned ID_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ-1:0]           we;
  logic [NUM_REQ*ADDR_BITS-1:0] addr;
  logic [NUM_REQ*DATA_BITS-1:0] wdata;
  logic [NUM_REQ-1:0]           ack;
  logic [DATA_BITS-1:0]         rdata;

  logic [ADDR_BITS-1:0]         bus_addr;
  logic [DATA_BITS-1:0]         bus_wdata;
  logic                         bus_w_en;
  logic                         bus_r_en;
  logic [DATA_BITS-1:0]         bus_rdata;

  logic                         busy;
  logic [ID_BITS-1:0]           grant_id;

  modport slave (
    input  req, we, addr, wdata, bus_rdata,
    output ack, rdata, bus_addr, bus_wdata, bus_w_en, bus_r_en, busy, grant_id
  );

  modport master (
    output req, we, addr, wdata, bus_rdata,
    input  ack, rdata, bus_addr, bus_wdata, bus_w_en, bus_r_en, busy, grant_id
  );
endinterface

// File: rtl/led_bus_arbiter.sv
// Round-robin arbiter that serialises single-register requests onto the
// led_controller bus: one setup cycle, one strobe cycle, then an ack cycle.
module led_bus_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned ADDR_BITS = 4,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic               clk_400K,
  input  logic               reset,
  led_bus_arbiter_if.slave   bif
);
  localparam int unsigned ID_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e               state_q;
  logic [ID_BITS-1:0]   last_q;
  logic [ID_BITS-1:0]   grant_q;
  logic                 we_q;
  logic [ADDR_BITS-1:0] bus_addr_q;
  logic [DATA_BITS-1:0] bus_wdata_q;
  logic                 bus_w_en_q;
  logic                 bus_r_en_q;
  logic                 busy_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic [DATA_BITS-1:0] rdata_q;

  logic [ID_BITS-1:0]   cand_c;
  logic [ID_BITS-1:0]   win_c;
  logic                 win_vld_c;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    cand_c    = '0;
    win_c     = '0;
    win_vld_c = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_c = ID_BITS'((32'(last_q) + 32'd1 + k) % NUM_REQ);
      if (!win_vld_c && bif.req[cand_c]) begin
        win_c     = cand_c;
        win_vld_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_400K) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= ID_BITS'(NUM_REQ - 1);
      grant_q     <= '0;
      we_q        <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_w_en_q  <= 1'b0;
      bus_r_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      ack_q       <= '0;
      rdata_q     <= '0;
    end else begin
      ack_q <= '0;
      unique case (state_q)
        IDLE: begin
          bus_w_en_q <= 1'b0;
          bus_r_en_q <= 1'b0;
          if (win_vld_c) begin
            grant_q     <= win_c;
            we_q        <= bif.we[win_c];
            bus_addr_q  <= bif.addr[32'(win_c)*ADDR_BITS +: ADDR_BITS];
            bus_wdata_q <= bif.wdata[32'(win_c)*DATA_BITS +: DATA_BITS];
            busy_q      <= 1'b1;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          bus_w_en_q <= we_q;
          bus_r_en_q <= ~we_q;
          state_q    <= STROBE;
        end
        STROBE: begin
          bus_w_en_q <= 1'b0;
          bus_r_en_q <= 1'b0;
          if (!we_q) rdata_q <= bif.bus_rdata;
          ack_q   <= NUM_REQ'(1) << grant_q;
          state_q <= DONE;
        end
        DONE: begin
          last_q  <= grant_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bif.ack       = ack_q;
  assign bif.rdata     = rdata_q;
  assign bif.bus_addr  = bus_addr_q;
  assign bif.bus_wdata = bus_wdata_q;
  assign bif.bus_w_en  = bus_w_en_q;
  assign bif.bus_r_en  = bus_r_en_q;
  assign bif.busy      = busy_q;
  assign bif.grant_id  = grant_q;
endmodule

// File: doc/led_bus_arbiter.md
Name: led_bus_arbiter

Overview:
Round-robin arbiter and bus sequencer that lets NUM_REQ independent requesters share the led_controller register bus. Example requesters are the host command port and a fade/pattern engine. Each requester issues a single-register read or write with a req/ack handshake. The block serialises the requests and drives the bus with the controller's required timing: address/data setup for one cycle, then a one-cycle enable strobe. It sits between the requesters and the bus_if led_ctrl side; the top level tristates bus_wdata onto the bus data lines while bus_w_en is high.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
ADDR_BITS, 4, register address width (matches reg_enum_t)
DATA_BITS, 8, register data width

Ports:
clk_400K  in  1  400 kHz system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester transaction request; held high until ack
we  in  NUM_REQ  per-requester op select: 1 = write, 0 = read
addr  in  NUM_REQ*ADDR_BITS  flattened per-requester register address (requester i at [i*ADDR_BITS +: ADDR_BITS])
wdata  in  NUM_REQ*DATA_BITS  flattened per-requester write data
ack  out  NUM_REQ  one-cycle completion pulse to the granted requester
rdata  out  DATA_BITS  read result; valid in the ack cycle, holds until the next read completes
bus_addr  out  ADDR_BITS  register address to controller
bus_wdata  out  DATA_BITS  write data to controller
bus_w_en  out  1  write strobe
bus_r_en  out  1  read strobe
bus_rdata  in  DATA_BITS  data returned by controller during the read strobe
busy  out  1  high in any state other than IDLE
grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester

Behaviour:
- FSM states: IDLE, SETUP, STROBE, DONE.
- Reset (synchronous), applied in the next cycle from any state:
  - state goes to IDLE.
  - ack, bus_w_en, bus_r_en, busy all 0.
  - bus_addr, bus_wdata, rdata, grant_id all 0.
  - round-robin pointer set so requester 0 has highest priority.
- Reset mid-transaction: any strobe in progress is dropped the cycle after reset is sampled, and no ack is issued.
- IDLE:
  - If any req bit is high, select a winner by round robin: search from (last_grant+1) mod NUM_REQ upward.
  - Latch winner's we, addr and wdata into holding registers; set grant_id; go to SETUP.
  - No req bit high: stay in IDLE with all strobes low.
- SETUP (1 cycle): bus_addr/bus_wdata driven from the latched values; both strobes low.
- STROBE (1 cycle):
  - Latched write: bus_w_en=1.
  - Latched read: bus_r_en=1, and rdata captures bus_rdata at the end of this cycle.
  - bus_addr/bus_wdata stay stable throughout.
- DONE (1 cycle): ack[grant_id]=1, strobes low, last_grant updated to grant_id; go to IDLE.
- Latency: req first seen in IDLE at cycle T gives SETUP at T+1, STROBE at T+2, ack at T+3, IDLE at T+4. Minimum 4 cycles per transaction.
- Handshake rules:
  - A requester must drop req in the cycle after it sees ack.
  - req still high when the FSM is back in IDLE at T+4 counts as a new request.
  - Inputs are sampled only at grant. Changes to we/addr/wdata, or req deasserted, after grant do not affect the transaction, which still completes with an ack.
- Never more than one ack bit high; bus_w_en and bus_r_en are never high together.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0,...
- Simultaneous new req and DONE: the request is seen in the following IDLE cycle.
- Addresses are passed through unchecked; an unmapped address is ignored by the controller and still acked.
- bus_addr/bus_wdata hold their last values in IDLE.

Test Plan:
1. Reset, then req[0] write addr=REG_PWM0 data=8'h40 -> SETUP at T+1; bus_w_en=1 only at T+2 with bus_addr=REG_PWM0 and bus_wdata=8'h40; ack[0] at T+3; a controller readback returns 8'h40.
2. req[1] read REG_PWM0 after scenario 1 -> bus_r_en=1 at T+2; rdata=8'h40 at the ack[1] cycle; rdata holds 8'h40 afterward.
3. req[0] and req[1] asserted together and held, writing REG_PWM0=8'h11 and REG_PWM1=8'h22 -> grant order 0,1,0,1; ack pulses 4 cycles apart; never two acks or two strobes in the same cycle.
4. Request accepted, then we/addr/wdata changed and req dropped during SETUP -> bus shows the originally latched values; ack still pulses at T+3.
5. reset asserted during STROBE of a write to REG_GRPPWM=8'hC0 -> next cycle all strobes 0, busy=0, no ack, GRPPWM unchanged; next request from requester 0 wins over simultaneous requester 1.
6. Sustained requests from requester 1 only, with requester 0 idle -> back-to-back grants to 1 every 4 cycles; busy low exactly one cycle (IDLE) between transactions.
